femtosoc_memctl: RTL and testbench
==================================

Name: femtosoc_memctl

Overview:
Parametrised memory controller between the PicoRV32 native memory port and the SoC's memories and peripherals. Decodes each CPU request to on-chip RAM with configurable wait states, or to one of NUM_IO peripheral channels. Unmapped accesses, and peripherals that never answer, terminate with an error response instead of hanging the core. Replaces the fixed single-RAM/single-iomem glue in the FemtoSoC top.

Parameters:
MEM_WORDS, 1024, on-chip RAM depth in 32-bit words; RAM occupies 0x0000_0000..4*MEM_WORDS-1.
RAM_WAIT, 0, extra wait cycles (0..15) before a RAM access is issued.
NUM_IO, 2, number of peripheral channels (1..8); channel k decodes mem_addr[31:24] == k+1.
IO_EXEC, 0, 1 = instruction fetch from IO regions allowed; 0 = such a fetch is an error.
TIMEOUT_CYCLES, 255, IO wait limit in cycles (1..65535).
ERR_RDATA, 32'h0000_0000, read data returned on any error response.
INIT_FILE, "", hex image loaded into RAM at elaboration; empty = no preload.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
mem_valid  in  1  CPU request valid; held until mem_ready
mem_instr  in  1  request is an instruction fetch
mem_addr  in  32  byte address; bits [1:0] ignored
mem_wdata  in  32  write data
mem_wstrb  in  4  byte write enables; 0 = read
mem_ready  out  1  one-cycle completion pulse
mem_rdata  out  32  read data, valid while mem_ready=1
io_valid  out  NUM_IO  one-hot channel request
io_addr  out  32  registered copy of mem_addr
io_wdata  out  32  registered copy of mem_wdata
io_wstrb  out  4  registered copy of mem_wstrb
io_ready  in  NUM_IO  per-channel completion
io_rdata  in  32*NUM_IO  per-channel read data; channel k in bits [32k+31:32k]
bus_err  out  1  one-cycle pulse, coincident with mem_ready, on an error response
err_addr  out  32  address of the most recent error
err_count  out  8  saturating error counter

Behaviour:
- Reset (async assert) forces state IDLE immediately; all outputs go to 0 and io_valid drops at once. RAM contents are kept. A RAM write not yet issued is never performed. Release is synchronous to clk.
- FSM states: IDLE, RAM, IO, DONE.
- IDLE, mem_valid=1: latch addr, wdata, wstrb, instr, then decode:
  - mem_addr[31:24]==0 and addr < 4*MEM_WORDS -> RAM, wait_cnt=RAM_WAIT.
  - mem_addr[31:24] in 1..NUM_IO, and not (mem_instr && !IO_EXEC) -> IO, timeout counter cleared.
  - Anything else -> DONE with error.
- RAM state: decrement wait_cnt. When wait_cnt==0, issue exactly one access (byte writes per wstrb, sync read), then go to DONE. Read latency, mem_valid seen to mem_ready: 2+RAM_WAIT cycles.
- IO state: io_valid[k]=1, with io_addr/io_wdata/io_wstrb stable. On io_ready[k]=1, capture io_rdata[k] and go to DONE; io_valid drops the next cycle. Minimum IO latency is 2 cycles. io_ready on non-selected channels is ignored.
- DONE: mem_ready=1 for exactly one cycle, then IDLE.
  - mem_rdata = RAM output, the captured IO data, or ERR_RDATA on error. Writes return 0.
  - mem_valid is not sampled in DONE, so back-to-back requests restart from IDLE the next cycle.
- Error response: bus_err=1 alongside mem_ready; err_addr latched; err_count increments and saturates at 255. Writes to unmapped addresses have no side effect.
- Once accepted in IDLE, a transaction always completes even if mem_valid drops.
- Address 4*MEM_WORDS exactly is unmapped. RAM_WAIT=0 adds no extra cycle.

Optional Feature:
FEMTOSOC_MEMCTL_TIMEOUT_EN
- Defined: the timeout counter runs in IO state. Reaching TIMEOUT_CYCLES without io_ready drops io_valid, goes to DONE and signals an error response.
- Undefined: no counter is built and IO waits indefinitely; unmapped and exec-denied errors remain.

Decomposition:
- Package femtosoc_pkg: FSM state encoding, REGION_RAM=8'h00, IO region base offset (1), error-cause constants, RAM_WAIT width.
- Sub-module femtosoc_ram_bank: byte-write synchronous single-port RAM with WORDS and INIT_FILE parameters; one-cycle read latency.

Test Plan:
- RAM_WAIT=0: write 0xA5A5_1234 to 0x10 with wstrb=4'b0011, then read 0x10 -> mem_ready 2 cycles after mem_valid, rdata=0x0000_1234 (RAM preloaded to 0).
- RAM_WAIT=3: read 0x0 -> mem_ready exactly 5 cycles after mem_valid; single-cycle pulse.
- IO channel 1 (addr 0x0200_0004): io_ready returned after 4 cycles with rdata 0xCAFE_F00D -> io_valid=2'b10 for 4 cycles, mem_rdata=0xCAFE_F00D, bus_err=0.
- Unmapped read at 0x0900_0000 with NUM_IO=2 -> mem_ready in 1 cycle, rdata=ERR_RDATA, bus_err=1, err_addr=0x0900_0000, err_count=1; a fetch from 0x0100_0000 with IO_EXEC=0 also errors.
- TIMEOUT_EN with TIMEOUT_CYCLES=8 and a silent channel 0 -> io_valid drops after 8 cycles, bus_err=1; 300 such errors leave err_count=255.
- Assert reset while in IO state and during a RAM_WAIT=3 write -> io_valid=0 immediately, mem_ready never pulses, target RAM word unchanged.

Source files
------------

// File: rtl/femtosoc_pkg.sv
// Shared types and constants for the FemtoSoC memory controller: FSM states,
// region decode constants and error causes.
package femtosoc_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RAM, S_IO, S_DONE} state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_UNMAPPED, ERR_EXEC, ERR_TIMEOUT} err_t;

  localparam logic [7:0] REGION_RAM = 8'h00;
  localparam logic [7:0] IO_BASE    = 8'h01;
  localparam int         WAIT_W     = 4;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/femtosoc_ram_bank.sv
// Byte-write synchronous single-port RAM, one-cycle read latency.
// Contents are never reset.
module femtosoc_ram_bank #(
  parameter int WORDS     = 1024,
  parameter int AW        = 10,
  parameter     INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int b = 0; b < 4; b++)
        if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/femtosoc_memctl.sv
// PicoRV32 native-port memory controller: on-chip RAM with wait states, NUM_IO
// peripheral channels, error responses. FEMTOSOC_MEMCTL_TIMEOUT_EN adds an IO timeout.
module femtosoc_memctl
  import femtosoc_pkg::*;
#(
  parameter int          MEM_WORDS      = 1024,
  parameter int          RAM_WAIT       = 0,
  parameter int          NUM_IO         = 2,
  parameter bit          IO_EXEC        = 1'b0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000,
  parameter              INIT_FILE      = ""
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_valid,
  input  logic                   mem_instr,
  input  logic [31:0]            mem_addr,
  input  logic [31:0]            mem_wdata,
  input  logic [3:0]             mem_wstrb,
  output logic                   mem_ready,
  output logic [31:0]            mem_rdata,
  output logic [NUM_IO-1:0]      io_valid,
  output logic [31:0]            io_addr,
  output logic [31:0]            io_wdata,
  output logic [3:0]             io_wstrb,
  input  logic [NUM_IO-1:0]      io_ready,
  input  logic [32*NUM_IO-1:0]   io_rdata,
  output logic                   bus_err,
  output logic [31:0]            err_addr,
  output logic [7:0]             err_count
);
  localparam int                AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int                CW        = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
  localparam logic [31:0]       RAM_BYTES = 32'(4 * MEM_WORDS);
  localparam logic [7:0]        IO_LAST   = 8'(IO_BASE + NUM_IO - 1);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(RAM_WAIT);

  state_t              r_state;
  err_t                r_cause;
  logic [31:0]         r_addr, r_wdata, r_io_data, r_err_addr;
  logic [3:0]          r_wstrb;
  logic [WAIT_W-1:0]   r_wait;
  logic [CW-1:0]       r_ch;
  logic [NUM_IO-1:0]   r_io_valid;
  logic                r_is_ram;
  logic [7:0]          r_err_cnt;

  logic [7:0]  w_top;
  logic        w_ram_hit, w_io_hit, w_exec_deny, w_io_rdy, w_ram_en, w_tmo;
  logic [CW-1:0] w_ch;
  logic [31:0] w_ram_rdata, w_sel_data;

  assign w_top       = mem_addr[31:24];
  assign w_ram_hit   = (w_top == REGION_RAM) && (mem_addr < RAM_BYTES);
  assign w_io_hit    = (w_top >= IO_BASE) && (w_top <= IO_LAST);
  assign w_exec_deny = mem_instr && !IO_EXEC;
  assign w_ch        = CW'(w_top - IO_BASE);
  assign w_io_rdy    = |(io_ready & r_io_valid);
  assign w_sel_data  = io_rdata[32*int'(r_ch) +: 32];
  assign w_ram_en    = (r_state == S_RAM) && (r_wait == '0);

`ifdef FEMTOSOC_MEMCTL_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_tmo;
  assign w_tmo = (r_tmo == TMO_LAST);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 r_tmo <= '0;
    else if (r_state != S_IO)  r_tmo <= '0;
    else if (!w_io_rdy)        r_tmo <= r_tmo + 16'd1;
  end
`else
  assign w_tmo = 1'b0;
`endif

  femtosoc_ram_bank #(.WORDS(MEM_WORDS), .AW(AW), .INIT_FILE(INIT_FILE)) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_en ? r_wstrb : 4'h0),
    .i_addr  (r_addr[AW+1:2]),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cause    <= ERR_NONE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_wait     <= '0;
      r_ch       <= '0;
      r_io_valid <= '0;
      r_io_data  <= '0;
      r_is_ram   <= 1'b0;
      r_err_addr <= '0;
      r_err_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (mem_valid) begin
          r_addr   <= mem_addr;
          r_wdata  <= mem_wdata;
          r_wstrb  <= mem_wstrb;
          r_cause  <= ERR_NONE;
          r_is_ram <= w_ram_hit;
          if (w_ram_hit) begin
            r_wait  <= WAIT_INIT;
            r_state <= S_RAM;
          end else if (w_io_hit && !w_exec_deny) begin
            r_ch       <= w_ch;
            r_io_valid <= NUM_IO'(1) << w_ch;
            r_state    <= S_IO;
          end else begin
            // Unmapped or exec-denied: no side effect, answer immediately.
            r_cause    <= w_io_hit ? ERR_EXEC : ERR_UNMAPPED;
            r_err_addr <= mem_addr;
            r_err_cnt  <= sat_inc8(r_err_cnt);
            r_state    <= S_DONE;
          end
        end
        S_RAM: begin
          if (r_wait == '0) r_state <= S_DONE;
          else              r_wait  <= r_wait - 1'b1;
        end
        S_IO: begin
          if (w_io_rdy) begin
            r_io_data  <= w_sel_data;
            r_io_valid <= '0;
            r_state    <= S_DONE;
          end else if (w_tmo) begin
            r_io_valid <= '0;
            r_cause    <= ERR_TIMEOUT;
            r_err_addr <= r_addr;
            r_err_cnt  <= sat_inc8(r_err_cnt);
            r_state    <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_rdata = 32'h0;
    if (r_state == S_DONE) begin
      if (r_cause != ERR_NONE)  mem_rdata = ERR_RDATA;
      else if (r_wstrb != 4'h0) mem_rdata = 32'h0;
      else if (r_is_ram)        mem_rdata = w_ram_rdata;
      else                      mem_rdata = r_io_data;
    end
  end

  assign mem_ready = (r_state == S_DONE);
  assign bus_err   = (r_state == S_DONE) && (r_cause != ERR_NONE);
  assign io_valid  = r_io_valid;
  assign io_addr   = r_addr;
  assign io_wdata  = r_wdata;
  assign io_wstrb  = r_wstrb;
  assign err_addr  = r_err_addr;
  assign err_count = r_err_cnt;
endmodule

// File: tb/tb_femtosoc_memctl.sv
// Directed bench: two controllers (RAM_WAIT=0 with IO channels, RAM_WAIT=3 with a
// 256-word RAM), a scoreboard of expected responses and a scripted IO responder.
module tb_femtosoc_memctl;
  localparam logic [31:0] ERRD = 32'hDEAD_0BAD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        mv [2], mi [2], rdy [2], berr [2];
  logic [31:0] ma [2], mwd [2], rd [2], ioa [2], iowd [2], eaddr [2];
  logic [3:0]  mws [2], iows [2];
  logic [1:0]  iov [2], ior [2];
  logic [63:0] iord [2];
  logic [7:0]  ecnt [2];

  femtosoc_memctl #(.MEM_WORDS(1024), .RAM_WAIT(0), .NUM_IO(2), .IO_EXEC(1'b0),
                    .TIMEOUT_CYCLES(8), .ERR_RDATA(ERRD)) u_dut0 (
    .clk(clk), .reset(rst[0]), .mem_valid(mv[0]), .mem_instr(mi[0]), .mem_addr(ma[0]),
    .mem_wdata(mwd[0]), .mem_wstrb(mws[0]), .mem_ready(rdy[0]), .mem_rdata(rd[0]),
    .io_valid(iov[0]), .io_addr(ioa[0]), .io_wdata(iowd[0]), .io_wstrb(iows[0]),
    .io_ready(ior[0]), .io_rdata(iord[0]), .bus_err(berr[0]), .err_addr(eaddr[0]),
    .err_count(ecnt[0]));

  femtosoc_memctl #(.MEM_WORDS(256), .RAM_WAIT(3), .NUM_IO(2), .IO_EXEC(1'b0),
                    .TIMEOUT_CYCLES(8), .ERR_RDATA(ERRD)) u_dut1 (
    .clk(clk), .reset(rst[1]), .mem_valid(mv[1]), .mem_instr(mi[1]), .mem_addr(ma[1]),
    .mem_wdata(mwd[1]), .mem_wstrb(mws[1]), .mem_ready(rdy[1]), .mem_rdata(rd[1]),
    .io_valid(iov[1]), .io_addr(ioa[1]), .io_wdata(iowd[1]), .io_wstrb(iows[1]),
    .io_ready(ior[1]), .io_rdata(iord[1]), .bus_err(berr[1]), .err_addr(eaddr[1]),
    .err_count(ecnt[1]));

  // IO responder for dut0: answers channel k after dly_k cycles of io_valid (0 = never).
  int          dly0 = 0, dly1 = 0, cnt = 0, v1cnt = 0;
  logic [1:0]  rr = 2'b00, nz = 2'b00;
  logic [31:0] aseen = '0, wseen = '0;
  logic [3:0]  sseen = '0;
  always @(negedge clk) begin
    if (iov[0] != 2'b00) begin
      cnt <= cnt + 1;
      if (iov[0] == 2'b10) v1cnt <= v1cnt + 1;
      aseen <= ioa[0];
      wseen <= iowd[0];
      sseen <= iows[0];
      rr <= ((iov[0][1] ? dly1 : dly0) != 0 && cnt + 1 >= (iov[0][1] ? dly1 : dly0)) ? iov[0] : 2'b00;
    end else begin
      cnt <= 0;
      rr  <= 2'b00;
    end
  end
  assign ior[0]  = rr | nz;
  assign ior[1]  = 2'b00;
  assign iord[0] = 64'hCAFE_F00D_1111_0000;
  assign iord[1] = 64'h0;

  typedef struct { logic [31:0] rdata; logic err; int lat; } exp_t;
  exp_t sb [$];
  int   npass = 0, ntot = 0;
  int   nerr [2] = '{0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic xact(input int d, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input logic ins, input logic [31:0] er,
                      input logic ee, input int el, input string tag);
    exp_t e;
    int   cyc = 0;
    sb.push_back('{rdata: er, err: ee, lat: el});
    @(negedge clk);
    mv[d] = 1'b1; mi[d] = ins; ma[d] = a; mwd[d] = wd; mws[d] = ws;
    do begin @(negedge clk); cyc++; end while (rdy[d] !== 1'b1 && cyc < 100);
    e = sb.pop_front();
    mv[d] = 1'b0; mi[d] = 1'b0; mws[d] = 4'h0;
    chk({tag, " latency"}, 32'(cyc), 32'(e.lat));
    chk({tag, " rdata"}, rd[d], e.rdata);
    chk({tag, " bus_err"}, 32'(berr[d]), 32'(e.err));
    if (e.err) begin
      nerr[d]++;
      chk({tag, " err_addr"}, eaddr[d], a);
      chk({tag, " err_count"}, 32'(ecnt[d]), (nerr[d] > 255) ? 32'd255 : 32'(nerr[d]));
    end
    @(negedge clk);
    chk({tag, " ready pulse"}, 32'(rdy[d]), 32'd0);
  endtask

  initial begin
    int pulses;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; mv[d] = 1'b0; mi[d] = 1'b0; ma[d] = '0; mwd[d] = '0; mws[d] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst mem_ready", 32'(rdy[0]), 32'd0);
    chk("rst io_valid", 32'(iov[0]), 32'd0);
    chk("rst bus_err", 32'(berr[0]), 32'd0);
    chk("rst err_count", 32'(ecnt[0]), 32'd0);
    chk("rst err_addr", eaddr[0], 32'd0);
    rst[0] = 1'b0; rst[1] = 1'b0;

    // dut0: RAM, zero wait states
    xact(0, 32'h10, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, 2, "w0 clear");
    xact(0, 32'h10, 32'hA5A5_1234, 4'b0011, 1'b0, 32'h0, 1'b0, 2, "w0 half");
    xact(0, 32'h10, 32'h0, 4'h0, 1'b0, 32'h0000_1234, 1'b0, 2, "r0 half");
    xact(0, 32'hFFC, 32'h89AB_CDEF, 4'hF, 1'b0, 32'h0, 1'b0, 2, "w0 last");
    xact(0, 32'hFFC, 32'h0, 4'h0, 1'b1, 32'h89AB_CDEF, 1'b0, 2, "r0 last");
    xact(0, 32'h0, 32'h5555_AAAA, 4'hF, 1'b0, 32'h0, 1'b0, 2, "w0 word0");
    xact(0, 32'h1000, 32'h1234_5678, 4'hF, 1'b0, ERRD, 1'b1, 1, "w0 beyond");
    xact(0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h5555_AAAA, 1'b0, 2, "r0 word0");
    xact(0, 32'h0900_0000, 32'h0, 4'h0, 1'b0, ERRD, 1'b1, 1, "r0 unmapped");
    xact(0, 32'h0100_0000, 32'h0, 4'h0, 1'b1, ERRD, 1'b1, 1, "fetch io");

    // dut0: IO channels (stray io_ready on ch0 must be ignored during ch1)
    dly1 = 4; nz = 2'b01;
    xact(0, 32'h0200_0004, 32'h0, 4'h0, 1'b0, 32'hCAFE_F00D, 1'b0, 5, "io ch1");
    nz = 2'b00;
    chk("io ch1 valid cycles", 32'(v1cnt), 32'd4);
    chk("io ch1 addr", aseen, 32'h0200_0004);
    dly0 = 1;
    xact(0, 32'h0100_0008, 32'h7788_99AA, 4'b1100, 1'b0, 32'h0, 1'b0, 2, "io ch0 w");
    chk("io ch0 wdata", wseen, 32'h7788_99AA);
    chk("io ch0 wstrb", 32'(sseen), 32'hC);
    xact(0, 32'h0100_000C, 32'h0, 4'h0, 1'b0, 32'h1111_0000, 1'b0, 2, "io ch0 r");
`ifdef FEMTOSOC_MEMCTL_TIMEOUT_EN
    dly0 = 0;
    xact(0, 32'h0100_0000, 32'h0, 4'h0, 1'b0, ERRD, 1'b1, 9, "io timeout");
`else
    dly0 = 20;
    xact(0, 32'h0100_0000, 32'h0, 4'h0, 1'b0, 32'h1111_0000, 1'b0, 21, "io slow");
`endif

    // error counter saturation
    while (nerr[0] < 300)
      xact(0, 32'h0900_0000, 32'h0, 4'h0, 1'b0, ERRD, 1'b1, 1, "sat");
    chk("err_count saturated", 32'(ecnt[0]), 32'd255);

    // reset while waiting on a silent IO channel
    dly0 = 0;
    @(negedge clk);
    mv[0] = 1'b1; ma[0] = 32'h0100_0010; mws[0] = 4'h0;
    repeat (3) @(negedge clk);
    chk("io pending valid", 32'(iov[0]), 32'd1);
    mv[0] = 1'b0;
    #2 rst[0] = 1'b1;
    #1;
    chk("io reset valid drop", 32'(iov[0]), 32'd0);
    chk("io reset err_count", 32'(ecnt[0]), 32'd0);
    chk("io reset io_addr", ioa[0], 32'd0);
    nerr[0] = 0;
    @(negedge clk);
    rst[0] = 1'b0;
    pulses = 0;
    repeat (4) begin @(negedge clk); if (rdy[0]) pulses++; end
    chk("io reset no ready", 32'(pulses), 32'd0);
    xact(0, 32'h10, 32'h0, 4'h0, 1'b0, 32'h0000_1234, 1'b0, 2, "r0 kept");

    // dut1: RAM_WAIT=3, 256-word RAM
    xact(1, 32'h20, 32'h1111_2222, 4'hF, 1'b0, 32'h0, 1'b0, 5, "w3 word");
    xact(1, 32'h20, 32'h0, 4'h0, 1'b0, 32'h1111_2222, 1'b0, 5, "r3 word");
    xact(1, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 5, "w3 zero");
    xact(1, 32'h400, 32'h0, 4'h0, 1'b0, ERRD, 1'b1, 1, "r3 beyond");
    @(negedge clk);
    mv[1] = 1'b1; ma[1] = 32'h20; mwd[1] = 32'hDEAD_BEEF; mws[1] = 4'hF;
    pulses = 0;
    repeat (3) begin @(negedge clk); if (rdy[1]) pulses++; end
    mv[1] = 1'b0; mws[1] = 4'h0;
    #2 rst[1] = 1'b1;
    #1;
    chk("ram reset ready", 32'(rdy[1]), 32'd0);
    chk("ram reset io_valid", 32'(iov[1]), 32'd0);
    chk("ram reset io_wdata", iowd[1], 32'd0);
    chk("ram reset io_wstrb", 32'(iows[1]), 32'd0);
    chk("ram reset io_addr", ioa[1], 32'd0);
    nerr[1] = 0;
    @(negedge clk);
    rst[1] = 1'b0;
    repeat (8) begin @(negedge clk); if (rdy[1]) pulses++; end
    chk("ram reset no ready", 32'(pulses), 32'd0);
    xact(1, 32'h20, 32'h0, 4'h0, 1'b0, 32'h1111_2222, 1'b0, 5, "r3 unchanged");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
